// File: rtl/alu_seq_if.sv
// alu_seq_unit command/result bus.
// Carries the valid/ready handshake, the decode fields, the operands and the result.
interface alu_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      alu_op;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport master (
    output in_valid, alu_op, funct3, funct7b5,
    output op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_op, funct3, funct7b5,
    input  op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_seq_unit.sv
// Handshaked decode+execute unit: 1-cycle ALU ops, 1 bit/cycle shifts.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier.
module alu_seq_unit #(
  parameter int XLEN = 32
) (
  input logic       clk,
  input logic       rst_n,
  input logic       flush,
  alu_seq_if.slave  bus
);
  localparam int SHW = $clog2(XLEN);
  localparam int CW  = SHW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef ALU_SEQ_MUL_EN
    MUL   = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    K_ADD, K_SUB, K_SLL, K_SLT, K_SLTU, K_XOR,
    K_SRL, K_SRA, K_OR, K_AND, K_MUL, K_ILL
  } kind_t;

  state_t          r_state, w_state;
  kind_t           w_kind;
  logic [XLEN-1:0] w_alu, w_sh, w_fin;
  logic [XLEN-1:0] r_acc, w_acc;
  logic [XLEN-1:0] r_result, w_result;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic [SHW-1:0]  w_shamt;
  logic            r_shl, w_shl, r_sra, w_sra;
  logic            r_zero, w_zero;
  logic            r_illegal, w_illegal;
  logic            w_done, w_fin_ill, w_is_sh;
`ifdef ALU_SEQ_MUL_EN
  logic [XLEN-1:0] r_ma, w_ma, r_mb, w_mb, w_mac;
`endif

  assign w_shamt = bus.op_b[SHW-1:0];
  assign w_is_sh = (w_kind == K_SLL) || (w_kind == K_SRL) ||
                   (w_kind == K_SRA);
  assign w_sh    = r_shl ? {r_acc[XLEN-2:0], 1'b0}
                         : {r_sra & r_acc[XLEN-1], r_acc[XLEN-1:1]};
`ifdef ALU_SEQ_MUL_EN
  assign w_mac   = r_mb[0] ? r_acc + r_ma : r_acc;
`endif

  // Decode alu_op/funct3/funct7b5 into an operation kind.
  always_comb begin
    w_kind = K_ILL;
    unique case (bus.alu_op)
      3'b000: w_kind = K_ADD;
      3'b001: w_kind = K_SUB;
      3'b010, 3'b011: begin
        unique case (bus.funct3)
          3'b000: w_kind = (bus.alu_op == 3'b010 && bus.funct7b5)
                           ? K_SUB : K_ADD;
          3'b001: w_kind = K_SLL;
          3'b010: w_kind = K_SLT;
          3'b011: w_kind = K_SLTU;
          3'b100: w_kind = K_XOR;
          3'b101: w_kind = bus.funct7b5 ? K_SRA : K_SRL;
          3'b110: w_kind = K_OR;
          3'b111: w_kind = K_AND;
        endcase
      end
`ifdef ALU_SEQ_MUL_EN
      3'b100: w_kind = K_MUL;
`endif
      default: w_kind = K_ILL;
    endcase
  end

  // Single-cycle result; a shift by zero passes op_a through.
  always_comb begin
    w_alu = '0;
    case (w_kind)
      K_ADD:  w_alu = bus.op_a + bus.op_b;
      K_SUB:  w_alu = bus.op_a - bus.op_b;
      K_SLT:  w_alu = {{(XLEN-1){1'b0}},
                       $signed(bus.op_a) < $signed(bus.op_b)};
      K_SLTU: w_alu = {{(XLEN-1){1'b0}}, bus.op_a < bus.op_b};
      K_XOR:  w_alu = bus.op_a ^ bus.op_b;
      K_OR:   w_alu = bus.op_a | bus.op_b;
      K_AND:  w_alu = bus.op_a & bus.op_b;
      K_SLL, K_SRL, K_SRA: w_alu = bus.op_a;
      default: w_alu = '0;
    endcase
  end

  // Next state and datapath; flush overrides everything.
  always_comb begin
    w_state   = r_state;
    w_acc     = r_acc;
    w_cnt     = r_cnt;
    w_shl     = r_shl;
    w_sra     = r_sra;
    w_result  = r_result;
    w_zero    = r_zero;
    w_illegal = r_illegal;
    w_done    = 1'b0;
    w_fin     = '0;
    w_fin_ill = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    w_ma      = r_ma;
    w_mb      = r_mb;
`endif
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          if (w_is_sh && w_shamt != '0) begin
            w_state = SHIFT;
            w_acc   = bus.op_a;
            w_cnt   = {1'b0, w_shamt};
            w_shl   = (w_kind == K_SLL);
            w_sra   = (w_kind == K_SRA);
`ifdef ALU_SEQ_MUL_EN
          end else if (w_kind == K_MUL) begin
            w_state = MUL;
            w_acc   = '0;
            w_ma    = bus.op_a;
            w_mb    = bus.op_b;
            w_cnt   = CW'(XLEN);
`endif
          end else begin
            w_done    = 1'b1;
            w_fin     = w_alu;
            w_fin_ill = (w_kind == K_ILL);
          end
        end
      end
      SHIFT: begin
        w_acc = w_sh;
        w_cnt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_done = 1'b1;
          w_fin  = w_sh;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      MUL: begin
        w_acc = w_mac;
        w_ma  = {r_ma[XLEN-2:0], 1'b0};
        w_mb  = {1'b0, r_mb[XLEN-1:1]};
        w_cnt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_done = 1'b1;
          w_fin  = w_mac;
        end
      end
`endif
      DONE: begin
        if (bus.out_ready) w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
    if (w_done) begin
      w_state   = DONE;
      w_result  = w_fin;
      w_zero    = (w_fin == '0);
      w_illegal = w_fin_ill;
    end
    if (flush) begin
      w_state   = IDLE;
      w_acc     = '0;
      w_cnt     = '0;
      w_result  = '0;
      w_zero    = 1'b0;
      w_illegal = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_shl     <= 1'b0;
      r_sra     <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      r_ma      <= '0;
      r_mb      <= '0;
`endif
    end else begin
      r_acc     <= w_acc;
      r_cnt     <= w_cnt;
      r_shl     <= w_shl;
      r_sra     <= w_sra;
      r_result  <= w_result;
      r_zero    <= w_zero;
      r_illegal <= w_illegal;
`ifdef ALU_SEQ_MUL_EN
      r_ma      <= w_ma;
      r_mb      <= w_mb;
`endif
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.illegal   = r_illegal;
endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: vector table, randomized ops vs a
// reference model, and handshake/flush/reset sequences.
module tb_alu_seq_unit;
  localparam int XLEN = 32;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   errors = 0;
  int   checks = 0;

  alu_seq_if #(.XLEN(XLEN)) bus ();

  alu_seq_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: RISC-V semantics in plain arithmetic.
  task automatic model(input logic [2:0] op, input logic [2:0] f3,
                       input logic f7, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] r,
                       output logic ill, output int lat);
    int sh;
    sh  = int'(b[4:0]);
    r   = 32'd0;
    ill = 1'b0;
    lat = 1;
    if (op == 3'd0) r = a + b;
    else if (op == 3'd1) r = a - b;
    else if (op == 3'd2 || op == 3'd3) begin
      case (f3)
        3'd0: r = (f7 && op == 3'd2) ? a - b : a + b;
        3'd1: begin r = a << sh; lat = sh + 1; end
        3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: begin
          if (f7) r = $signed(a) >>> sh;
          else    r = a >> sh;
          lat = sh + 1;
        end
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end
`ifdef ALU_SEQ_MUL_EN
    else if (op == 3'd4) begin
      r   = a * b;
      lat = XLEN + 1;
    end
`endif
    else ill = 1'b1;
  endtask

  // Present one command for one cycle; it is accepted at that edge.
  task automatic launch(input logic [2:0] op, input logic [2:0] f3,
                        input logic f7, input logic [31:0] a,
                        input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.funct3   = f3;
    bus.funct7b5 = f7;
    bus.op_a     = a;
    bus.op_b     = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.alu_op   = 3'($urandom);
    bus.op_a     = $urandom;
    bus.op_b     = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    launch(v.op, v.f3, v.f7, v.a, v.b);
    if (v.lat > 1) check({tag, ".busy_in_ready"}, 32'(bus.in_ready), 0);
    wait_done(lat);
    check({tag, ".latency"}, 32'(lat), 32'(v.lat));
    check({tag, ".result"}, bus.result, v.res);
    check({tag, ".zero"}, 32'(bus.zero), 32'(v.z));
    check({tag, ".illegal"}, 32'(bus.illegal), 32'(v.ill));
    @(posedge clk);
    #1;
    check({tag, ".back_to_idle"}, 32'(bus.in_ready), 1);
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    int   lat;
    logic [31:0] r0;
    logic [31:0] er;
    logic ei;
    int   el;
    logic [2:0] mop;

    bus.in_valid  = 1'b0;
    bus.alu_op    = '0;
    bus.funct3    = '0;
    bus.funct7b5  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.out_ready = 1'b1;

    tbl.push_back('{3'd0, 3'd0, 1'b0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1});
    tbl.push_back('{3'd1, 3'd0, 1'b0, 32'h1234, 32'h1234, 32'd0, 1'b1, 1'b0, 1});
    tbl.push_back('{3'd2, 3'd5, 1'b1, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0, 5});
    tbl.push_back('{3'd2, 3'd1, 1'b0, 32'hA5, 32'h20, 32'hA5, 1'b0, 1'b0, 1});
    tbl.push_back('{3'd2, 3'd0, 1'b1, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0, 1});
    tbl.push_back('{3'd3, 3'd0, 1'b1, 32'd10, 32'd3, 32'd13, 1'b0, 1'b0, 1});
    tbl.push_back('{3'd2, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1});
    tbl.push_back('{3'd2, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1});
    tbl.push_back('{3'd3, 3'd5, 1'b0, 32'h8000_0000, 32'h3F, 32'd1, 1'b0, 1'b0, 32});
    tbl.push_back('{3'd3, 3'd4, 1'b1, 32'hF0F0, 32'h0FF0, 32'hFF00, 1'b0, 1'b0, 1});
    tbl.push_back('{3'd7, 3'd0, 1'b0, 32'd9, 32'd9, 32'd0, 1'b1, 1'b1, 1});
    tbl.push_back('{3'd2, 3'd6, 1'b0, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0, 1});
    tbl.push_back('{3'd2, 3'd7, 1'b0, 32'hF0, 32'h3C, 32'h30, 1'b0, 1'b0, 1});
    tbl.push_back('{3'd1, 3'd0, 1'b0, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1});
    tbl.push_back('{3'd3, 3'd5, 1'b1, 32'h8000_0000, 32'd1, 32'hC000_0000, 1'b0, 1'b0, 2});
`ifdef ALU_SEQ_MUL_EN
    tbl.push_back('{3'd4, 3'd0, 1'b0, 32'd7, 32'd6, 32'd42, 1'b0, 1'b0, 33});
`else
    tbl.push_back('{3'd4, 3'd0, 1'b0, 32'd7, 32'd6, 32'd0, 1'b1, 1'b1, 1});
`endif

    repeat (2) @(posedge clk);
    #1;
    check("reset.in_ready", 32'(bus.in_ready), 1);
    check("reset.out_valid", 32'(bus.out_valid), 0);
    check("reset.result", bus.result, 0);
    check("reset.zero", 32'(bus.zero), 0);
    check("reset.illegal", 32'(bus.illegal), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 80; i++) begin
      v.op = 3'($urandom_range(0, 7));
      v.f3 = 3'($urandom);
      v.f7 = 1'($urandom);
      v.a  = $urandom;
      v.b  = ($urandom_range(0, 3) == 0) ? v.a : $urandom;
      model(v.op, v.f3, v.f7, v.a, v.b, er, ei, el);
      v.res = er;
      v.ill = ei;
      v.lat = el;
      v.z   = (er == 32'd0);
      run_vec(v, $sformatf("rnd%0d", i));
    end

    // Backpressure: result held while out_ready is low.
`ifdef ALU_SEQ_MUL_EN
    mop = 3'd4;
`else
    mop = 3'd2;
`endif
    model(mop, 3'd5, 1'b1, 32'd7, 32'd6, er, ei, el);
    bus.out_ready = 1'b0;
    launch(mop, 3'd5, 1'b1, 32'd7, 32'd6);
    wait_done(lat);
    check("bp.latency", 32'(lat), 32'(el));
    check("bp.result", bus.result, er);
    r0 = bus.result;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("bp.hold_valid", 32'(bus.out_valid), 1);
      check("bp.hold_in_ready", 32'(bus.in_ready), 0);
      check("bp.hold_result", bus.result, r0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp.release_in_ready", 32'(bus.in_ready), 1);
    check("bp.release_valid", 32'(bus.out_valid), 0);

    // Flush in the middle of a long shift drops the op.
    launch(3'd2, 3'd1, 1'b0, 32'h1, 32'd20);
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_shift.out_valid", 32'(bus.out_valid), 0);
    check("flush_shift.in_ready", 32'(bus.in_ready), 1);
    lat = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) lat++;
    end
    check("flush_shift.no_result", 32'(lat), 0);

    // Flush while a result waits in DONE.
    bus.out_ready = 1'b0;
    launch(3'd0, 3'd0, 1'b0, 32'd1, 32'd2);
    wait_done(lat);
    check("flush_done.valid_before", 32'(bus.out_valid), 1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    check("flush_done.out_valid", 32'(bus.out_valid), 0);
    check("flush_done.in_ready", 32'(bus.in_ready), 1);

    // Flush has priority over accept.
    bus.in_valid = 1'b1;
    bus.alu_op   = 3'd0;
    bus.op_a     = 32'd3;
    bus.op_b     = 32'd4;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_acc.in_ready", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    check("flush_acc.no_valid", 32'(bus.out_valid), 0);

    // Asynchronous reset in the middle of a multi-cycle op.
`ifdef ALU_SEQ_MUL_EN
    launch(3'd4, 3'd0, 1'b0, 32'd3, 32'd5);
`else
    launch(3'd2, 3'd1, 1'b0, 32'd3, 32'd31);
`endif
    repeat (5) @(posedge clk);
    #1;
    check("rst_mid.busy", 32'(bus.in_ready), 0);
    rst_n = 1'b0;
    #1;
    check("rst_mid.in_ready", 32'(bus.in_ready), 1);
    check("rst_mid.out_valid", 32'(bus.out_valid), 0);
    check("rst_mid.result", bus.result, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_vec('{3'd7, 3'd3, 1'b1, 32'h55, 32'h66, 32'd0, 1'b1, 1'b1, 1},
            "post_abort_illegal");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
